accelerator_matrix_gate_product: RTL

ACCELERATOR_MATRIX_GATE_PRODUCT -- requirements
Module: accelerator_matrix_gate_product

---
 rtl/accelerator_matrix_gate_product.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/accelerator_matrix_gate_product.sv
// Element-wise gated product of two streamed matrices.
// Each output element is (A * B) >> (DATA_SIZE/2) in unsigned fixed point.
// A and B arrive row-major with separate "first column" (I) and
// "subsequent column" (J) strobes. One element is in flight at a time.
module accelerator_matrix_gate_product #(
    parameter int DATA_SIZE    = 64,
    parameter int CONTROL_SIZE = 4
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 START,
    output logic                 READY,
    input  logic                 DATA_A_IN_I_ENABLE,
    input  logic                 DATA_A_IN_J_ENABLE,
    input  logic                 DATA_B_IN_I_ENABLE,
    input  logic                 DATA_B_IN_J_ENABLE,
    output logic                 DATA_OUT_I_ENABLE,
    output logic                 DATA_OUT_J_ENABLE,
    input  logic [DATA_SIZE-1:0] SIZE_I_IN,
    input  logic [DATA_SIZE-1:0] SIZE_J_IN,
    input  logic [DATA_SIZE-1:0] DATA_A_IN,
    input  logic [DATA_SIZE-1:0] DATA_B_IN,
    output logic [DATA_SIZE-1:0] DATA_OUT
);

    localparam int HALF = DATA_SIZE / 2;

    typedef enum logic [2:0] {
        STARTER  = 3'd0,
        INPUT_I  = 3'd1,
        INPUT_J  = 3'd2,
        MULTIPLY = 3'd3,
        ENDER    = 3'd4
    } state_t;

    state_t                  state_q, state_d;
    logic [CONTROL_SIZE-1:0] index_i_q, index_i_d;
    logic [CONTROL_SIZE-1:0] index_j_q, index_j_d;
    logic                    flag_a_q, flag_a_d;
    logic                    flag_b_q, flag_b_d;
    logic [DATA_SIZE-1:0]    data_a_q, data_a_d;
    logic [DATA_SIZE-1:0]    data_b_q, data_b_d;
    logic [DATA_SIZE-1:0]    product_q, product_d;
    logic [DATA_SIZE-1:0]    data_out_q, data_out_d;
    logic                    ready_q, ready_d;
    logic                    out_i_en_q, out_i_en_d;
    logic                    out_j_en_q, out_j_en_d;

    // Helper nets: phase-selected strobes and last-index limits.
    logic                 a_en;
    logic                 b_en;
    logic [DATA_SIZE-1:0] last_i;
    logic [DATA_SIZE-1:0] last_j;
    logic [DATA_SIZE-1:0] index_i_ext;
    logic [DATA_SIZE-1:0] index_j_ext;
    logic                 is_last_i;
    logic                 is_last_j;

    // Row/column limits: a size of zero behaves like a size of one, and the
    // narrow indices are zero-extended before comparison.
    always_comb begin
        last_i      = (SIZE_I_IN == '0) ? '0 : SIZE_I_IN - DATA_SIZE'(1);
        last_j      = (SIZE_J_IN == '0) ? '0 : SIZE_J_IN - DATA_SIZE'(1);
        index_i_ext = {{(DATA_SIZE - CONTROL_SIZE){1'b0}}, index_i_q};
        index_j_ext = {{(DATA_SIZE - CONTROL_SIZE){1'b0}}, index_j_q};
        is_last_i   = (index_i_ext == last_i);
        is_last_j   = (index_j_ext == last_j);
    end

    // Only the strobes belonging to the current column phase are honoured.
    always_comb begin
        a_en = 1'b0;
        b_en = 1'b0;
        if (state_q == INPUT_I) begin
            a_en = DATA_A_IN_I_ENABLE;
            b_en = DATA_B_IN_I_ENABLE;
        end else if (state_q == INPUT_J) begin
            a_en = DATA_A_IN_J_ENABLE;
            b_en = DATA_B_IN_J_ENABLE;
        end
    end

    // Next-state and datapath: capture operands, multiply, emit, step indices.
    always_comb begin
        // NOTE: every variable gets a default here so no path leaves a value
        // unassigned; otherwise synthesis would infer a latch.
        state_d    = state_q;
        index_i_d  = index_i_q;
        index_j_d  = index_j_q;
        flag_a_d   = flag_a_q;
        flag_b_d   = flag_b_q;
        data_a_d   = data_a_q;
        data_b_d   = data_b_q;
        product_d  = product_q;
        data_out_d = data_out_q;
        ready_d    = 1'b0;
        out_i_en_d = 1'b0;
        out_j_en_d = 1'b0;

        case (state_q)
            STARTER: begin
                if (START) begin
                    index_i_d = '0;
                    index_j_d = '0;
                    flag_a_d  = 1'b0;
                    flag_b_d  = 1'b0;
                    state_d   = INPUT_I;
                end
            end

            INPUT_I, INPUT_J: begin
                // First value wins: once held, an operand ignores new strobes
                // until its element has been emitted.
                if (a_en && !flag_a_q) begin
                    data_a_d = DATA_A_IN;
                    flag_a_d = 1'b1;
                end
                if (b_en && !flag_b_q) begin
                    data_b_d = DATA_B_IN;
                    flag_b_d = 1'b1;
                end
                if (flag_a_d && flag_b_d) begin
                    state_d = MULTIPLY;
                end
            end

            MULTIPLY: begin
                // Full double-width product, shifted back to the fixed-point
                // scale and truncated; no rounding or saturation.
                product_d = DATA_SIZE'(({{DATA_SIZE{1'b0}}, data_a_q} *
                                        {{DATA_SIZE{1'b0}}, data_b_q}) >> HALF);
                state_d   = ENDER;
            end

            ENDER: begin
                data_out_d = product_q;
                out_j_en_d = 1'b1;
                flag_a_d   = 1'b0;
                flag_b_d   = 1'b0;
                if (is_last_i && is_last_j) begin
                    ready_d = 1'b1;
                    state_d = STARTER;
                end else if (is_last_j) begin
                    out_i_en_d = 1'b1;
                    index_i_d  = index_i_q + CONTROL_SIZE'(1);
                    index_j_d  = '0;
                    state_d    = INPUT_I;
                end else begin
                    index_j_d = index_j_q + CONTROL_SIZE'(1);
                    state_d   = INPUT_J;
                end
            end

            default: begin
                state_d = STARTER;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge CLK) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples its _d value from before this edge, independent of order.
        if (!RST) begin
            state_q    <= STARTER;
            index_i_q  <= '0;
            index_j_q  <= '0;
            flag_a_q   <= 1'b0;
            flag_b_q   <= 1'b0;
            data_a_q   <= '0;
            data_b_q   <= '0;
            product_q  <= '0;
            data_out_q <= '0;
            ready_q    <= 1'b0;
            out_i_en_q <= 1'b0;
            out_j_en_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            index_i_q  <= index_i_d;
            index_j_q  <= index_j_d;
            flag_a_q   <= flag_a_d;
            flag_b_q   <= flag_b_d;
            data_a_q   <= data_a_d;
            data_b_q   <= data_b_d;
            product_q  <= product_d;
            data_out_q <= data_out_d;
            ready_q    <= ready_d;
            out_i_en_q <= out_i_en_d;
            out_j_en_q <= out_j_en_d;
        end
    end

    assign READY             = ready_q;
    assign DATA_OUT_I_ENABLE = out_i_en_q;
    assign DATA_OUT_J_ENABLE = out_j_en_q;
    assign DATA_OUT          = data_out_q;

endmodule
